lbm_stream_addr_gen: RTL
========================

Name: lbm_stream_addr_gen

Overview:
- Sequential D2Q9 streaming address generator for the lattice-Boltzmann datapath.
- On `start`, sweeps every cell of an NX x NY grid, x-fastest, one cell per accepted cycle.
- For each cell, emits the nine post-streaming destination addresses and destination direction indices, with a valid mask.
- Supports drop, periodic and bounce-back boundaries. Sits between the collision unit and the distribution-memory write port, behind a valid/ready handshake.

Parameters:
NX, 16, grid width in cells (>=2)
NY, 16, grid height in cells (>=2)
BOUNDARY_MODE, 0, 0=drop out-of-grid writes, 1=periodic wrap, 2=bounce-back
ADDR_W, $clog2(NX*NY), cell address width
DIR_W, 4, direction index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle sweep request; ignored while busy
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after final bundle handshake
out_valid  out  1  bundle valid
out_ready  in  1  downstream accepts bundle
src_addr  out  ADDR_W  source cell address y*NX+x
wr_en  out  9  per-direction write enable, bit q = direction q
wr_addr  out  9*ADDR_W  destination addresses, slice q = [q*ADDR_W +: ADDR_W]
wr_dir  out  9*DIR_W  destination direction index per slice

Behaviour:
- Direction set, index q (cx,cy): 0(0,0) 1(1,0) 2(0,1) 3(-1,0) 4(0,-1) 5(1,1) 6(-1,1) 7(-1,-1) 8(1,-1).
- Opposite direction: 0<->0, 1<->3, 2<->4, 5<->7, 6<->8.
- Reset (async, rst_n=0): state IDLE, x=y=0, busy=0, done=0, out_valid=0, src_addr=0, wr_en=0, wr_addr=0, wr_dir=0.
- Reset mid-sweep aborts immediately. No resume.
- FSM states:
  - IDLE: start=1 -> SWEEP, with x=y=0.
  - SWEEP: load = !out_valid | out_ready. On load, register the bundle for (x,y), set out_valid=1, and advance x. x wraps NX-1 -> 0 and increments y. When loading cell (NX-1,NY-1) -> DRAIN.
  - DRAIN: out_valid & out_ready -> DONE, out_valid=0.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy = (state != IDLE). start in any non-IDLE state has no effect.
- Latency: start sampled at edge T -> out_valid high after edge T+1 with src_addr=0.
- With out_ready held high: one bundle per cycle, NX*NY bundles, done high during cycle T+NX*NY+2.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold unchanged and the counter does not advance.
- Per direction q: xs = x+cx[q], ys = y+cy[q]. Compute signed, one bit wider than max(clog2 NX, clog2 NY). oob = xs<0 | xs>=NX | ys<0 | ys>=NY.
- Not oob: wr_en[q]=1, wr_addr = ys*NX+xs, wr_dir = q.
- oob, mode 0: wr_en[q]=0, wr_addr = all ones, wr_dir = q.
- oob, mode 1: xs, ys each wrapped modulo NX/NY (adding or subtracting one period is sufficient). wr_en[q]=1, wr_dir = q.
- oob, mode 2: wr_en[q]=1, wr_addr = src_addr, wr_dir = opposite(q).
- Direction 0 is never oob.
- Corner cells have 5 oob directions; edge (non-corner) cells have 3.
- Multiplication by NX must be a constant multiply. No divider.
- All arithmetic is pure function of registered (x,y). Outputs are registered. No combinational path from out_ready to outputs except the load enable.

Test Plan:
- Reset/idle: hold rst_n=0 then release, start=0 for 10 cycles -> busy=0, out_valid=0, done=0, all outputs 0.
- Full sweep, mode 0, NX=NY=16, out_ready=1: start at T -> 256 bundles in src_addr order 0..255, done pulse in cycle T+258.
  - Cell (0,0): wr_en=9'b000100111, wr_addr[1]=1, wr_addr[2]=16, wr_addr[5]=17, wr_addr[3]=8'hFF.
- Periodic, NX=4, NY=3, cell (0,0): wr_addr[3]=3, wr_addr[4]=8, wr_addr[7]=11, wr_addr[6]=7, wr_addr[8]=9; wr_en=9'h1FF.
- Bounce-back, NX=4, NY=3, cell (3,2) (src 11): dirs 1,2,5,6,8 give wr_addr=11 with wr_dir=3,4,7,8,6. dir 3 gives addr 10, dir 4 gives addr 7, dir 7 gives addr 6.
- Backpressure: random out_ready with 50% duty -> no bundle lost or duplicated; outputs stable while stalled; exactly 256 handshakes then a single done; start pulses during sweep ignored.
- Reset mid-sweep: drop rst_n after 40 handshakes -> out_valid, busy immediately 0. New start restarts from src_addr=0.

Source files
------------

// File: rtl/lbm_stream_addr_gen.sv
// rtl/lbm_stream_addr_gen.sv - D2Q9 streaming destination address generator
// Sweeps the grid x-fastest and registers one nine-way write bundle per accepted cycle.
module lbm_stream_addr_gen #(
  parameter int NX            = 16,
  parameter int NY            = 16,
  parameter int BOUNDARY_MODE = 0,
  parameter int ADDR_W        = $clog2(NX * NY),
  parameter int DIR_W         = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     src_addr,
  output logic [8:0]            wr_en,
  output logic [9*ADDR_W-1:0]   wr_addr,
  output logic [9*DIR_W-1:0]    wr_dir
);

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [8:0]          wr_en_q, wr_en_d;
  logic [9*ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [9*DIR_W-1:0]  wr_dir_q, wr_dir_d;

  logic                load;
  logic                last_cell;
  logic                x_wrap;
  logic [ADDR_W-1:0]   nb_src;
  logic [8:0]          nb_en;
  logic [9*ADDR_W-1:0] nb_addr;
  logic [9*DIR_W-1:0]  nb_dir;
  int                  xs, ys, xw, yw;
  logic                oob;

  function automatic int dir_cx(input int q);
    case (q)
      1, 5, 8: return 1;
      3, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_cy(input int q);
    case (q)
      2, 5, 6: return 1;
      4, 7, 8: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_opp(input int q);
    case (q)
      1:       return 3;
      2:       return 4;
      3:       return 1;
      4:       return 2;
      5:       return 7;
      6:       return 8;
      7:       return 5;
      8:       return 6;
      default: return 0;
    endcase
  endfunction

  assign load      = (state_q == S_SWEEP) && (!out_valid_q || out_ready);
  assign x_wrap    = (x_q == XW'(NX - 1));
  assign last_cell = x_wrap && (y_q == YW'(NY - 1));

  // Next bundle for the current (x,y); a neighbour is at most one step outside the grid,
  // so a single add/subtract of the period suffices for wrapping.
  always_comb begin
    nb_src  = ADDR_W'(int'(y_q) * NX + int'(x_q));
    nb_en   = '0;
    nb_addr = '0;
    nb_dir  = '0;
    xs      = 0;
    ys      = 0;
    xw      = 0;
    yw      = 0;
    oob     = 1'b0;
    for (int q = 0; q < 9; q++) begin
      xs  = int'(x_q) + dir_cx(q);
      ys  = int'(y_q) + dir_cy(q);
      oob = (xs < 0) || (xs >= NX) || (ys < 0) || (ys >= NY);
      xw  = (xs < 0) ? xs + NX : ((xs >= NX) ? xs - NX : xs);
      yw  = (ys < 0) ? ys + NY : ((ys >= NY) ? ys - NY : ys);
      nb_dir[q*DIR_W +: DIR_W] = DIR_W'(q);
      if (!oob) begin
        nb_en[q]                    = 1'b1;
        nb_addr[q*ADDR_W +: ADDR_W] = ADDR_W'(ys * NX + xs);
      end else if (BOUNDARY_MODE == 1) begin
        nb_en[q]                    = 1'b1;
        nb_addr[q*ADDR_W +: ADDR_W] = ADDR_W'(yw * NX + xw);
      end else if (BOUNDARY_MODE == 2) begin
        nb_en[q]                    = 1'b1;
        nb_addr[q*ADDR_W +: ADDR_W] = nb_src;
        nb_dir[q*DIR_W +: DIR_W]    = DIR_W'(dir_opp(q));
      end else begin
        nb_en[q]                    = 1'b0;
        nb_addr[q*ADDR_W +: ADDR_W] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SWEEP;
      S_SWEEP: if (load && last_cell) state_d = S_DRAIN;
      S_DRAIN: if (out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    src_addr_d  = src_addr_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_dir_d    = wr_dir_q;
    if (state_q == S_IDLE && start) begin
      x_d = '0;
      y_d = '0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      src_addr_d  = nb_src;
      wr_en_d     = nb_en;
      wr_addr_d   = nb_addr;
      wr_dir_d    = nb_dir;
      if (x_wrap) begin
        x_d = '0;
        y_d = last_cell ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    if (state_q == S_DRAIN && out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      src_addr_q  <= '0;
      wr_en_q     <= '0;
      wr_addr_q   <= '0;
      wr_dir_q    <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      src_addr_q  <= src_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_dir_q    <= wr_dir_d;
    end
  end

  assign out_valid = out_valid_q;
  assign src_addr  = src_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_dir    = wr_dir_q;

endmodule
